id_ex_hazard_stage: RTL and testbench
=====================================

# id_ex_hazard_stage

ID/EX pipeline register with built-in hazard control for the five-stage MIPS core. It captures decoded operands and control from ID, detects load-use hazards and inserts a one-cycle bubble, and holds EX for a multi-cycle mult/div. It drives `ex_rs`/`ex_rt`/`ex_back` and the EX control bits consumed by the EX→MEM register and the EX-stage forwarding unit. It also produces the `pc_write`/`ifid_write` stall enables for IF and IF/ID.

## Interface
Parameters:
- `MD_LATENCY`, 8, EX occupancy in cycles of a mult/div instruction (≥1; 1 = no hold).

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in 5: register specifiers.
- `id_RegDst`, `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_MemtoReg` in 1: decoded control.
- `id_ALUOp` in 4: ALU operation.
- `id_md` in 1: instruction is mult/div.
- `id_rs_data`, `id_rt_data`, `id_imm` in 32: register-file read data and sign-extended immediate.
- `ex_flush` in 1: branch/jump resolved taken in EX this cycle.
- `pc_write`, `ifid_write` out 1: combinational enables for PC and IF/ID; 0 = stall.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_rs`, `ex_rt`, `ex_back` out 5: source specifiers and destination (`id_RegDst ? id_rd : id_rt`).
- `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg` out 1: registered control.
- `ex_ALUOp` out 4: registered ALU operation.
- `ex_md` out 1: registered `id_md`.
- `ex_rs_data`, `ex_rt_data`, `ex_imm` out 32: registered data.
- `ex_md_busy` out 1: FSM in BUSY.

## Operation
- **Registers and FSM**
  - Registers: all `ex_*` outputs, FSM state {IDLE, BUSY}, down-counter `cnt` of width $clog2(MD_LATENCY)+1.
- **Load-use hazard**
  - `load_use` = `ex_valid & ex_MemRead & (ex_back != 0) & id_valid & (id_rs == ex_back | id_rt == ex_back)`.
  - Evaluated only in IDLE.
- **Stall and hold**
  - `hold` = (state == BUSY).
  - `stall` = `~ex_flush & (hold | load_use)`.
  - `pc_write = ifid_write = ~stall`.
- **Per-edge action, in priority order**
  1. `ex_flush`: load bubble, state ← IDLE, cnt ← 0 (aborts any mult/div).
  2. `hold`: all `ex_*` registers keep their value. cnt ← cnt−1. When cnt == 1, state ← IDLE.
  3. `load_use`: load bubble.
  4. Otherwise, normal load:
     - Capture all `id_*` fields; `ex_valid` ← `id_valid`.
     - If `id_valid & id_md & MD_LATENCY > 1`: state ← BUSY, cnt ← MD_LATENCY−1.
- **Bubble**
  - All `ex_*` control, specifier and data outputs ← 0, including `ex_valid`, `ex_md`, `ex_back`, `ex_rs`, `ex_rt`.
  - A bubble therefore never matches a nonzero register in forwarding.
- **Instruction validity**
  - `id_valid = 0` under normal load stores the fields with `ex_valid = 0`.
  - It also forces `ex_RegWrite`, `ex_MemRead` and `ex_MemWrite` to 0.

## Timing
- **Reset**: every registered output is 0, state IDLE, cnt 0. After reset, `pc_write = ifid_write = 1` because no hazard is possible.
- **Latency**: ID → EX is one cycle. Outputs change only at `clk` rising edge or on `rst_n` assertion.
- **Load-use**
  - Stall lasts exactly 1 cycle; the EX bubble clears `load_use` on the next cycle.
  - The dependent instruction enters EX two cycles after the load did.
- **Mult/div**
  - The instruction occupies EX for exactly MD_LATENCY cycles.
  - `ex_md_busy` and stall are high for the first MD_LATENCY−1 of those cycles.
  - On the final cycle `stall` = 0 and the next instruction loads at its end.
- **Simultaneous events**
  - `ex_flush` with `load_use` or BUSY: flush wins; `pc_write` = 1 so the branch target is fetched.
  - `load_use` is never asserted while BUSY.
- **Reset mid-operation**: `rst_n` low during BUSY returns immediately to IDLE with all outputs 0.

## Test plan
- **Reset**: `rst_n` = 0 with random `id_*` inputs → all `ex_*` = 0 and `ex_md_busy` = 0. After release, `pc_write` = 1.
- **Load-use stall**:
  - Stimulus: `lw $8` (ex_MemRead = 1, ex_back = 8) followed by `add` with `id_rs` = 8.
  - Response: `pc_write` = `ifid_write` = 0 for 1 cycle; next EX is a bubble (`ex_valid` = 0). The following cycle `ex_rs` = 8 and `pc_write` = 1.
- **Load into $0**: same as above with `ex_back` = 0 → no stall.
- **Mult/div hold, MD_LATENCY = 4**:
  - Stimulus: `id_md` = 1, with a new instruction waiting in ID.
  - Response: `ex_md_busy` high 3 cycles with `ex_*` frozen; stall for 3 cycles; the next instruction reaches EX 4 cycles after the mult.
- **Flush priority**:
  - Case 1: `ex_flush` = 1 with `load_use` = 1 → bubble, `pc_write` = 1.
  - Case 2: `ex_flush` in cycle 2 of BUSY → state IDLE and bubble next cycle.
- **Async reset during BUSY**: `rst_n` pulsed low mid-hold → `ex_md_busy` = 0 immediately, and normal load resumes after release.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion and mult/div EX hold.
// Produces the PC / IF-ID write enables used to stall the front of the pipe.
module id_ex_hazard_stage #(
    parameter int unsigned MD_LATENCY = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_RegDst,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_MemtoReg,
    input  logic [3:0]  id_ALUOp,
    input  logic        id_md,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        ex_flush,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ex_valid,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_back,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_MemtoReg,
    output logic [3:0]  ex_ALUOp,
    output logic        ex_md,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic        ex_md_busy
);

    localparam int unsigned CNT_W   = $clog2(MD_LATENCY) + 1;
    localparam bit          MD_HOLD = (MD_LATENCY > 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic hold;
    logic load_use;
    logic stall;
    logic bubble;

    // Hazard detection and front-end stall enables; a taken branch always wins
    always_comb begin
        hold     = (state == BUSY);
        load_use = ~hold & ex_valid & ex_MemRead & (ex_back != 5'd0) & id_valid &
                   ((id_rs == ex_back) | (id_rt == ex_back));
        stall    = ~ex_flush & (hold | load_use);
        bubble   = ex_flush | load_use;
        pc_write   = ~stall;
        ifid_write = ~stall;
    end

    assign ex_md_busy = (state == BUSY);

    // Pipeline register plus the mult/div hold FSM and its occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_back     <= '0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_ALUOp    <= '0;
            ex_md       <= 1'b0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
        end else begin
            // Datapath: bubble on flush or load-use, freeze while holding, else capture ID
            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_rs       <= '0;
                ex_rt       <= '0;
                ex_back     <= '0;
                ex_RegWrite <= 1'b0;
                ex_MemRead  <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_MemtoReg <= 1'b0;
                ex_ALUOp    <= '0;
                ex_md       <= 1'b0;
                ex_rs_data  <= '0;
                ex_rt_data  <= '0;
                ex_imm      <= '0;
            end else if (!hold) begin
                ex_valid    <= id_valid;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_back     <= id_RegDst ? id_rd : id_rt;
                ex_RegWrite <= id_valid & id_RegWrite;
                ex_MemRead  <= id_valid & id_MemRead;
                ex_MemWrite <= id_valid & id_MemWrite;
                ex_MemtoReg <= id_MemtoReg;
                ex_ALUOp    <= id_ALUOp;
                ex_md       <= id_md;
                ex_rs_data  <= id_rs_data;
                ex_rt_data  <= id_rt_data;
                ex_imm      <= id_imm;
            end

            // Control: flush aborts a mult/div; hold counts down to the final EX cycle
            if (ex_flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (hold) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state <= IDLE;
                end
            end else if (!load_use && id_valid && id_md && MD_HOLD) begin
                state <= BUSY;
                cnt   <= CNT_W'(MD_LATENCY - 1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: vector table plus mult/div, flush and reset sequences.
module tb_id_ex_hazard_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
    logic [3:0]  id_ALUOp;
    logic        id_md;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        ex_flush;
    logic        pc_write, ifid_write, ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_back;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
    logic [3:0]  ex_ALUOp;
    logic        ex_md;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic        ex_md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_hazard_stage #(.MD_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
        .id_md(id_md), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .ex_flush(ex_flush), .pc_write(pc_write), .ifid_write(ifid_write),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_back(ex_back),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_ALUOp(ex_ALUOp), .ex_md(ex_md),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_md_busy(ex_md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        regdst, wr, mr, md;
        logic [31:0] rsd;
        logic        flush;
        logic        pcw;
        logic        ev;
        logic [4:0]  ers, eback;
        logic        ewr, emr;
        logic [31:0] erd;
        logic        busy;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic valid, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic regdst, input logic wr, input logic mr, input logic md,
        input logic [31:0] rsd, input logic flush,
        input logic pcw, input logic ev, input logic [4:0] ers, input logic [4:0] eback,
        input logic ewr, input logic emr, input logic [31:0] erd, input logic busy);
        vec_t v;
        v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd; v.regdst = regdst;
        v.wr = wr; v.mr = mr; v.md = md; v.rsd = rsd; v.flush = flush;
        v.pcw = pcw; v.ev = ev; v.ers = ers; v.eback = eback;
        v.ewr = ewr; v.emr = emr; v.erd = erd; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic regdst, input logic wr,
                       input logic mr, input logic md, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input logic flush);
        id_valid = valid; id_rs = rs; id_rt = rt; id_rd = rd; id_RegDst = regdst;
        id_RegWrite = wr; id_MemRead = mr; id_MemWrite = 1'b0; id_MemtoReg = mr;
        id_ALUOp = 4'h6; id_md = md; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        ex_flush = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // valid rs rt rd rdst wr mr md rsd flush | pcw ev ers eback ewr emr erd busy
        tbl[0]  = mk(1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 1'b0,  1'b1, 1'b1, 5'd1,  5'd3,  1'b1, 1'b0, 32'h11, 1'b0);
        tbl[1]  = mk(1'b1, 5'd4,  5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h22, 1'b0,  1'b1, 1'b1, 5'd4,  5'd8,  1'b1, 1'b1, 32'h22, 1'b0);
        tbl[2]  = mk(1'b1, 5'd8,  5'd5,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 32'h33, 1'b0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0,  1'b0);
        tbl[3]  = mk(1'b1, 5'd8,  5'd5,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 32'h33, 1'b0,  1'b1, 1'b1, 5'd8,  5'd9,  1'b1, 1'b0, 32'h33, 1'b0);
        tbl[4]  = mk(1'b1, 5'd6,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 1'b0,  1'b1, 1'b1, 5'd6,  5'd0,  1'b1, 1'b1, 32'h44, 1'b0);
        tbl[5]  = mk(1'b1, 5'd0,  5'd7,  5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 1'b0,  1'b1, 1'b1, 5'd0,  5'd10, 1'b1, 1'b0, 32'h55, 1'b0);
        tbl[6]  = mk(1'b1, 5'd1,  5'd12, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h66, 1'b0,  1'b1, 1'b1, 5'd1,  5'd12, 1'b1, 1'b1, 32'h66, 1'b0);
        tbl[7]  = mk(1'b1, 5'd2,  5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 32'h77, 1'b1,  1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0,  1'b0);
        tbl[8]  = mk(1'b0, 5'd12, 5'd12, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h78, 1'b0,  1'b1, 1'b0, 5'd12, 5'd12, 1'b0, 1'b0, 32'h78, 1'b0);
        tbl[9]  = mk(1'b1, 5'd3,  5'd14, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h88, 1'b0,  1'b1, 1'b1, 5'd3,  5'd14, 1'b1, 1'b1, 32'h88, 1'b0);
        tbl[10] = mk(1'b0, 5'd14, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h99, 1'b0,  1'b1, 1'b0, 5'd14, 5'd0,  1'b0, 1'b0, 32'h99, 1'b0);
        tbl[11] = mk(1'b1, 5'd0,  5'd15, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'hAA, 1'b0,  1'b1, 1'b1, 5'd0,  5'd15, 1'b1, 1'b1, 32'hAA, 1'b0);
        tbl[12] = mk(1'b1, 5'd0,  5'd15, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hBB, 1'b0,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0,  1'b0);
        tbl[13] = mk(1'b1, 5'd0,  5'd15, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'hBB, 1'b0,  1'b1, 1'b1, 5'd0,  5'd15, 1'b0, 1'b0, 32'hBB, 1'b0);

        // Reset with random ID inputs
        rst_n = 1'b0;
        drv(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
            $urandom, $urandom, $urandom, 1'b0);
        repeat (2) tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_back", 32'(ex_back), 32'd0);
        chk("rst_ex_rs_data", ex_rs_data, 32'd0);
        chk("rst_ex_MemRead", 32'(ex_MemRead), 32'd0);
        chk("rst_busy", 32'(ex_md_busy), 32'd0);
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_ifid_write", 32'(ifid_write), 32'd1);
        tick();

        // Table: load-use stalls, $0 loads, flush priority, invalid instructions
        for (int i = 0; i < NV; i++) begin
            drv(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].regdst, tbl[i].wr,
                tbl[i].mr, tbl[i].md, tbl[i].rsd, tbl[i].rsd + 32'd1, ~tbl[i].rsd, tbl[i].flush);
            #1;
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(tbl[i].pcw));
            chk($sformatf("v%0d_ifid_write", i), 32'(ifid_write), 32'(tbl[i].pcw));
            tick();
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_ex_rs", i), 32'(ex_rs), 32'(tbl[i].ers));
            chk($sformatf("v%0d_ex_back", i), 32'(ex_back), 32'(tbl[i].eback));
            chk($sformatf("v%0d_ex_RegWrite", i), 32'(ex_RegWrite), 32'(tbl[i].ewr));
            chk($sformatf("v%0d_ex_MemRead", i), 32'(ex_MemRead), 32'(tbl[i].emr));
            chk($sformatf("v%0d_ex_rs_data", i), ex_rs_data, tbl[i].erd);
            chk($sformatf("v%0d_busy", i), 32'(ex_md_busy), 32'(tbl[i].busy));
        end

        // Mult/div hold: MD_LATENCY=4 -> 3 busy/stall cycles, next instruction at cycle 4
        drv(1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 32'hA1, 32'hA2, 1'b0);
        #1;
        chk("md_pre_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("md_busy_start", 32'(ex_md_busy), 32'd1);
        chk("md_ex_md", 32'(ex_md), 32'd1);
        drv(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB0, 32'hB1, 32'hB2, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk($sformatf("md_k%0d_pc_write", k), 32'(pc_write), 32'd0);
            tick();
            chk($sformatf("md_k%0d_rs_data", k), ex_rs_data, 32'hA0);
            chk($sformatf("md_k%0d_ex_rs", k), 32'(ex_rs), 32'd2);
            chk($sformatf("md_k%0d_busy", k), 32'(ex_md_busy), (k < 3) ? 32'd1 : 32'd0);
        end
        #1;
        chk("md_last_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("md_next_ex_rs", 32'(ex_rs), 32'd5);
        chk("md_next_ex_back", 32'(ex_back), 32'd7);
        chk("md_next_rs_data", ex_rs_data, 32'hB0);
        chk("md_next_rt_data", ex_rt_data, 32'hB1);
        chk("md_next_imm", ex_imm, 32'hB2);
        chk("md_next_ALUOp", 32'(ex_ALUOp), 32'h6);
        chk("md_next_ex_md", 32'(ex_md), 32'd0);
        chk("md_next_busy", 32'(ex_md_busy), 32'd0);

        // Flush in the second BUSY cycle aborts the mult/div
        drv(1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0, 32'hC1, 32'hC2, 1'b0);
        tick();
        chk("fl_busy_start", 32'(ex_md_busy), 32'd1);
        drv(1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 32'hD0, 32'hD1, 32'hD2, 1'b0);
        #1;
        chk("fl_hold_pc_write", 32'(pc_write), 32'd0);
        tick();
        chk("fl_hold_busy", 32'(ex_md_busy), 32'd1);
        ex_flush = 1'b1;
        #1;
        chk("fl_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_ex_md", 32'(ex_md), 32'd0);
        chk("fl_busy", 32'(ex_md_busy), 32'd0);
        chk("fl_rs_data", ex_rs_data, 32'd0);
        ex_flush = 1'b0;
        #1;
        chk("fl_after_pc_write", 32'(pc_write), 32'd1);
        tick();
        chk("fl_after_ex_valid", 32'(ex_valid), 32'd1);
        chk("fl_after_rs_data", ex_rs_data, 32'hD0);

        // Asynchronous reset mid-hold
        drv(1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hE0, 32'hE1, 32'hE2, 1'b0);
        tick();
        chk("ar_busy_start", 32'(ex_md_busy), 32'd1);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(ex_md_busy), 32'd0);
        chk("ar_ex_valid", 32'(ex_valid), 32'd0);
        chk("ar_rs_data", ex_rs_data, 32'd0);
        chk("ar_pc_write", 32'(pc_write), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 5'd17, 5'd18, 5'd19, 1'b1, 1'b1, 1'b0, 1'b0, 32'hF0, 32'hF1, 32'hF2, 1'b0);
        tick();
        chk("ar_resume_ex_valid", 32'(ex_valid), 32'd1);
        chk("ar_resume_back", 32'(ex_back), 32'd19);
        chk("ar_resume_rs_data", ex_rs_data, 32'hF0);
        chk("ar_resume_busy", 32'(ex_md_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
